// File: rtl/slp_pkg.sv
// slp_pkg: shared width, function-select and route-select encodings for the serial logic datapath
package slp_pkg;
   localparam int SLP_WIDTH = 8;
   typedef enum logic [2:0] {
      F_AND  = 3'b000,
      F_OR   = 3'b001,
      F_XOR  = 3'b010,
      F_ONE  = 3'b011,
      F_NAND = 3'b100,
      F_NOR  = 3'b101,
      F_XNOR = 3'b110,
      F_ZERO = 3'b111
   } func_e;
   typedef enum logic [1:0] {
      R_ROT  = 2'b00,
      R_TO_B = 2'b01,
      R_TO_A = 2'b10,
      R_SWAP = 2'b11
   } route_e;
endpackage

// File: rtl/shift_reg.sv
// shift_reg: right-shift register with parallel load (load beats shift) and async active-low reset
module shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic             shift_en,
   input  logic             sin,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q
);
   // load over shift over hold; serial bit enters at the MSB
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (ld) q <= din;
      else if (shift_en) q <= {sin, q[WIDTH-1:1]};
endmodule

// File: rtl/serial_logic_datapath.sv
// serial_logic_datapath: A/B operand registers with a bit-serial logic unit and result router
// Optional feature macro SHIFT_CNT_EN adds the Shift_Cnt/Done ports and the shift counter.
module serial_logic_datapath
   import slp_pkg::*;
#(
   parameter int WIDTH = SLP_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Ld_A,
   input  logic             Ld_B,
   input  logic             Shift_En,
   input  logic [WIDTH-1:0] Din,
   input  logic [2:0]       F,
   input  logic [1:0]       R,
   output logic [WIDTH-1:0] A_out,
   output logic [WIDTH-1:0] B_out
`ifdef SHIFT_CNT_EN
   ,
   output logic [$clog2(WIDTH):0] Shift_Cnt,
   output logic                   Done
`endif
);
   logic f, a_in, b_in;
   // bitwise function of the two register LSBs
   always_comb begin
      f = 1'b0;
      case (func_e'(F))
         F_AND:  f = A_out[0] & B_out[0];
         F_OR:   f = A_out[0] | B_out[0];
         F_XOR:  f = A_out[0] ^ B_out[0];
         F_ONE:  f = 1'b1;
         F_NAND: f = ~(A_out[0] & B_out[0]);
         F_NOR:  f = ~(A_out[0] | B_out[0]);
         F_XNOR: f = ~(A_out[0] ^ B_out[0]);
         F_ZERO: f = 1'b0;
         default: f = 1'b0;
      endcase
   end
   // choose which serial bit re-enters each register
   always_comb begin
      a_in = A_out[0];
      b_in = B_out[0];
      case (route_e'(R))
         R_ROT:  begin a_in = A_out[0]; b_in = B_out[0]; end
         R_TO_B: begin a_in = A_out[0]; b_in = f;        end
         R_TO_A: begin a_in = f;        b_in = B_out[0]; end
         R_SWAP: begin a_in = B_out[0]; b_in = A_out[0]; end
         default: ;
      endcase
   end
   shift_reg #(.WIDTH(WIDTH)) u_a (
      .clk(Clk), .rst_n(Reset_n), .ld(Ld_A), .shift_en(Shift_En),
      .sin(a_in), .din(Din), .q(A_out)
   );
   shift_reg #(.WIDTH(WIDTH)) u_b (
      .clk(Clk), .rst_n(Reset_n), .ld(Ld_B), .shift_en(Shift_En),
      .sin(b_in), .din(Din), .q(B_out)
   );
`ifdef SHIFT_CNT_EN
   localparam int CW = $clog2(WIDTH) + 1;
   logic [CW-1:0] cnt_nxt;
   assign cnt_nxt = (Shift_Cnt == CW'(WIDTH)) ? CW'(1) : Shift_Cnt + CW'(1);
   // count shifts since the last load; Done pulses for the cycle after the count reaches WIDTH
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         Shift_Cnt <= '0;
         Done      <= 1'b0;
      end else if (Ld_A || Ld_B) begin
         Shift_Cnt <= '0;
         Done      <= 1'b0;
      end else if (Shift_En) begin
         Shift_Cnt <= cnt_nxt;
         Done      <= cnt_nxt == CW'(WIDTH);
      end else begin
         Done      <= 1'b0;
      end
`endif
endmodule

// File: tb/tb_serial_logic_datapath.sv
// tb_serial_logic_datapath: randomized + directed scoreboard bench for serial_logic_datapath
module tb_serial_logic_datapath;
   logic       Clk = 0, Reset_n = 0, Ld_A = 0, Ld_B = 0, Shift_En = 0;
   logic [7:0] Din = 0;
   logic [2:0] F = 0;
   logic [1:0] R = 0;
   logic [7:0] A_out, B_out;
`ifdef SHIFT_CNT_EN
   logic [3:0] Shift_Cnt;
   logic       Done;
`endif
   int checks = 0, errors = 0;
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         cnt;
      bit         done;
   } exp_t;
   exp_t q[$];
   exp_t e;
   logic [7:0] ma = 0, mb = 0;
   int         mcnt = 0;
   bit         mdone = 0;

   always #5 Clk = ~Clk;

   serial_logic_datapath dut (
      .Clk(Clk), .Reset_n(Reset_n), .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En),
      .Din(Din), .F(F), .R(R), .A_out(A_out), .B_out(B_out)
`ifdef SHIFT_CNT_EN
      , .Shift_Cnt(Shift_Cnt), .Done(Done)
`endif
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit fn(int f, bit a, bit b);
      case (f)
         0: return a & b;
         1: return a | b;
         2: return a ^ b;
         3: return 1'b1;
         4: return !(a & b);
         5: return !(a | b);
         6: return a == b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic step(bit la, bit lb, bit sh, logic [7:0] d, int f, int r);
      bit fb, ain, bin;
      @(negedge Clk);
      Ld_A = la; Ld_B = lb; Shift_En = sh; Din = d; F = 3'(f); R = 2'(r);
      @(posedge Clk);
      fb  = fn(f, ma[0], mb[0]);
      ain = (r == 2) ? fb : (r == 3) ? mb[0] : ma[0];
      bin = (r == 1) ? fb : (r == 3) ? ma[0] : mb[0];
      if (la) ma = d; else if (sh) ma = (ma >> 1) | (8'(ain) << 7);
      if (lb) mb = d; else if (sh) mb = (mb >> 1) | (8'(bin) << 7);
      if (la || lb) begin mcnt = 0; mdone = 0; end
      else if (sh) begin mcnt = (mcnt == 8) ? 1 : mcnt + 1; mdone = (mcnt == 8); end
      else mdone = 0;
      q.push_back('{ma, mb, mcnt, mdone});
      #1;
      Ld_A = 0; Ld_B = 0; Shift_En = 0;
   endtask

   task automatic shifts(int n, int f, int r);
      repeat (n) step(0, 0, 1, 8'h00, f, r);
   endtask

   task automatic load(logic [7:0] a, logic [7:0] b);
      step(1, 0, 0, a, 0, 0);
      step(0, 1, 0, b, 0, 0);
   endtask

   task automatic settle();
      @(negedge Clk);
      #1;
   endtask

   // monitor: compare DUT registers against the oldest expected entry each cycle
   always @(negedge Clk)
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("mon_a", 32'(A_out), 32'(e.a));
         chk("mon_b", 32'(B_out), 32'(e.b));
`ifdef SHIFT_CNT_EN
         chk("mon_cnt", 32'(Shift_Cnt), 32'(e.cnt));
         chk("mon_done", 32'(Done), 32'(e.done));
`endif
      end

   initial begin
      #3;
      chk("rst_a", 32'(A_out), 0);
      chk("rst_b", 32'(B_out), 0);
`ifdef SHIFT_CNT_EN
      chk("rst_cnt", 32'(Shift_Cnt), 0);
      chk("rst_done", 32'(Done), 0);
`endif
      @(negedge Clk);
      Reset_n = 1;
      load(8'h33, 8'h55);
      shifts(8, 2, 2);
      settle();
      chk("xor_a", 32'(A_out), 'h66);
      chk("xor_b", 32'(B_out), 'h55);
`ifdef SHIFT_CNT_EN
      chk("xor_done_hi", 32'(Done), 1);
`endif
      step(0, 0, 0, 8'h00, 0, 0);
      settle();
`ifdef SHIFT_CNT_EN
      chk("xor_done_lo", 32'(Done), 0);
`endif
      load(8'hF0, 8'hCC);
      shifts(8, 0, 1);
      settle();
      chk("and_a", 32'(A_out), 'hF0);
      chk("and_b", 32'(B_out), 'hC0);
      load(8'h12, 8'h34);
      shifts(4, int'($urandom_range(7)), 3);
      settle();
      chk("swap4_a", 32'(A_out), 'h41);
      chk("swap4_b", 32'(B_out), 'h23);
      shifts(4, int'($urandom_range(7)), 3);
      settle();
      chk("swap8_a", 32'(A_out), 'h34);
      chk("swap8_b", 32'(B_out), 'h12);
      load(8'hA5, 8'h0F);
      shifts(8, 7, 2);
      settle();
      chk("zero_a", 32'(A_out), 'h00);
      chk("zero_b", 32'(B_out), 'h0F);
      shifts(8, 3, 2);
      settle();
      chk("one_a", 32'(A_out), 'hFF);
      chk("one_b", 32'(B_out), 'h0F);
      load(8'h5A, 8'h3C);
      shifts(3, 2, 2);
      settle();
      Reset_n = 0;
      #1;
      chk("arst_a", 32'(A_out), 0);
      chk("arst_b", 32'(B_out), 0);
`ifdef SHIFT_CNT_EN
      chk("arst_cnt", 32'(Shift_Cnt), 0);
`endif
      ma = 0; mb = 0; mcnt = 0; mdone = 0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      #1;
      Reset_n = 1;
      repeat (6) step(0, 0, 0, 8'h00, 0, 0);
      settle();
`ifdef SHIFT_CNT_EN
      chk("arst_nodone", 32'(Done), 0);
`endif
      load(8'h00, 8'h01);
      step(1, 0, 1, 8'h81, 1, 1);
      settle();
      chk("ldsh_a", 32'(A_out), 'h81);
      chk("ldsh_b", 32'(B_out), 'h80);
`ifdef SHIFT_CNT_EN
      chk("ldsh_cnt", 32'(Shift_Cnt), 0);
`endif
      load(8'($urandom), 8'($urandom));
      shifts(20, int'($urandom_range(7)), int'($urandom_range(3)));
      for (int i = 0; i < 400; i++) begin
         int k;
         k = int'($urandom_range(11));
         step(k == 0 || k == 2 || k == 3, k == 1 || k == 2, k >= 3 && k != 4,
              8'($urandom), int'($urandom_range(7)), int'($urandom_range(3)));
      end
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge Clk);
      #1;
      chk("drain", 32'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_logic_datapath.md
# serial_logic_datapath

Register and bit-serial compute datapath for the 8-bit serial logic processor. It sits directly downstream of the control state machine and consumes its `Ld_A`, `Ld_B` and `Shift_En` strobes. It holds operand registers A and B, loads them in parallel from the switches, and computes one of eight bitwise functions one bit per shift cycle. The result is routed back into A and/or B so that the result is complete after WIDTH shifts.

## Interface
- `WIDTH`, default 8: operand register width.
- `Clk`  in  1: system clock; all state updates on the rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `Ld_A`  in  1: parallel-load A from `Din` (from control).
- `Ld_B`  in  1: parallel-load B from `Din` (from control).
- `Shift_En`  in  1: shift A and B right one bit (from control).
- `Din`  in  WIDTH: parallel load data (switches).
- `F`  in  3: function select.
- `R`  in  2: route select.
- `A_out`  out  WIDTH: contents of register A.
- `B_out`  out  WIDTH: contents of register B.
- `Shift_Cnt`  out  $clog2(WIDTH)+1: number of shifts since the last load (present only with the macro).
- `Done`  out  1: one-cycle pulse after the WIDTH-th shift (present only with the macro).

## Operation
- Serial bit: `f = func(A[0], B[0])`, combinational from the current register LSBs.
- F encodings:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 constant 1
  - 100 NAND
  - 101 NOR
  - 110 XNOR
  - 111 constant 0
- Router, giving (A_in, B_in):
  - R=00: (A[0], B[0]), both registers rotate.
  - R=01: (A[0], f), result goes to B.
  - R=10: (f, B[0]), result goes to A.
  - R=11: (B[0], A[0]), swap.
- Shift: `A <= {A_in, A[WIDTH-1:1]}`, and likewise for B with `B_in`.
- Per-register priority: load over shift, shift over hold.
  - `Ld_A` with `Shift_En`: A loads `Din`. B shifts, using the `B_in` computed from the pre-edge A[0].
  - `Ld_A` with `Ld_B`: both registers load `Din`.
- `F` and `R` are sampled on every shift edge. Changing them mid-operation takes effect on the next shift. No latching.

## Timing
- Reset values: `A_out`=0, `B_out`=0, `Shift_Cnt`=0, `Done`=0.
  - Reset is asynchronous, so it takes effect immediately, including mid-operation.
  - Partial results are discarded.
- Load and shift each have 1-cycle latency: the register output reflects the change after the rising edge on which the strobe was high.
- `A_out` and `B_out` come straight from flops; no combinational path from the inputs.
- `f` and the router are combinational; nothing is pipelined.
- A full operation is WIDTH consecutive `Shift_En` cycles. Control supplies exactly 8 for WIDTH=8.

## Configuration
- `SHIFT_CNT_EN` defined: `Shift_Cnt` and `Done` ports plus the counter logic exist.
  - Counter clears on any load.
  - Counter increments on each shift and wraps WIDTH→1 on further shifts.
  - `Done` is a registered pulse, high for exactly the one cycle following the edge at which the count reaches WIDTH.
  - Simultaneous load and shift: the load wins, so the count is 0.
- `SHIFT_CNT_EN` undefined: both ports and the counter are absent. Datapath behaviour is identical.

## Structure
- Shared package `slp_pkg`:
  - `func_e` enum for the F encodings.
  - `route_e` enum for the R encodings.
  - Localparam `SLP_WIDTH = 8`.
- One sub-module, `shift_reg`: WIDTH-bit right-shift register with `Ld`, `Shift_En`, serial in, parallel in/out and asynchronous active-low reset. It is instantiated twice, for A and B.
- The compute function and router are `always_comb` blocks in the top module.

## Test plan
- Load A=0x33, load B=0x55, F=010, R=10, 8 shifts → A_out=0x66, B_out=0x55. With the macro, `Done` is high exactly one cycle after the 8th shift edge.
- A=0xF0, B=0xCC, F=000, R=01, 8 shifts → A_out=0xF0, B_out=0xC0.
- A=0x12, B=0x34, R=11, any F, 8 shifts → A_out=0x34, B_out=0x12. After 4 shifts: A_out=0x41, B_out=0x23.
- A=0xA5, B=0x0F, F=111, R=10, 8 shifts → A_out=0x00. Then F=011, 8 more shifts → A_out=0xFF, B_out=0x0F throughout.
- Assert `Reset_n` low after 3 of 8 shifts → A_out=B_out=0 and `Shift_Cnt`=0 immediately, without waiting for a clock edge. No `Done` pulse follows.
- `Ld_A` and `Shift_En` together with Din=0x81, A=0x00, B=0x01, R=01, F=001 → A_out=0x81, B_out=0x80, `Shift_Cnt`=0.
